// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// PC increment, bubble encoding and the opcode field position.
package if_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 21;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int unsigned PC_INCR    = 4;
    localparam int unsigned STATE_W    = 2;

    // All-zero word decodes to a no-write bubble downstream.
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0;

    // Fetch FSM state encoding.
    typedef logic [STATE_W-1:0] if_state_t;
    localparam logic [STATE_W-1:0] FETCH   = 2'd0;
    localparam logic [STATE_W-1:0] HOLD    = 2'd1;
    localparam logic [STATE_W-1:0] DISCARD = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports: clock/reset; flush (highest priority, inserts bubble), hold (keep
// contents), load (capture next_pc/next_instr); with none of them asserted
// the register advances to a bubble. Outputs valid/pc/instr.
module if_id_reg
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               flush,
    input  logic               hold,
    input  logic [ADDR_W-1:0]  next_pc,
    input  logic [INSTR_W-1:0] next_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    // Flush beats hold so a redirect always squashes a stalled slot.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= BUBBLE_INSTR;
        end else if (!hold) begin
            if (load) begin
                valid <= 1'b1;
                pc    <= next_pc;
                instr <= next_instr;
            end else begin
                valid <= 1'b0;
                pc    <= '0;
                instr <= BUBBLE_INSTR;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues req/ready fetches to
// instruction memory, and feeds the IF/ID register.
// Ports: clock, reset (sync, active high); imem_req/imem_addr/imem_ready/
// imem_rdata memory handshake; id_stall, redirect, redirect_target from
// later stages; if_id_valid/pc/instr/opcode to decode.
module if_stage
    import if_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                id_stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_target,
    output logic                if_id_valid,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [OPCODE_W-1:0] if_id_opcode
);

    if_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  buf_pc_q, buf_pc_d;

    logic               id_load, id_flush;
    logic [ADDR_W-1:0]  id_pc_d;
    logic [INSTR_W-1:0] id_instr_d;
    logic [ADDR_W-1:0]  target_al;
    logic [ADDR_W-1:0]  req_addr_inc;

    assign target_al    = redirect_target & ~ADDR_W'(3);
    assign req_addr_inc = req_addr_q + ADDR_W'(PC_INCR);

    // Request stays up in DISCARD so an abandoned transfer is never retracted.
    assign imem_req  = (state_q != HOLD);
    assign imem_addr = req_addr_q;

    // State and fetch-address registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= BUBBLE_INSTR;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    // Next-state, PC and IF/ID control; redirect > id_stall > advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        id_load     = 1'b0;
        id_flush    = 1'b0;
        id_pc_d     = req_addr_q;
        id_instr_d  = imem_rdata;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    id_flush = 1'b1;
                    pc_d     = target_al;
                    if (imem_ready) begin
                        req_addr_d = target_al;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_d       = req_addr_inc;
                    req_addr_d = req_addr_inc;
                    if (id_stall) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_addr_q;
                        state_d     = HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    id_flush    = 1'b1;
                    pc_d        = target_al;
                    req_addr_d  = target_al;
                    buf_instr_d = BUBBLE_INSTR;
                    buf_pc_d    = '0;
                    state_d     = FETCH;
                end else if (!id_stall) begin
                    id_load    = 1'b1;
                    id_pc_d    = buf_pc_q;
                    id_instr_d = buf_instr_q;
                    state_d    = FETCH;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    id_flush = 1'b1;
                    pc_d     = target_al;
                end
                // Abandoned transfer finishes; restart at the newest target.
                if (imem_ready) begin
                    req_addr_d = redirect ? target_al : pc_q;
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (id_load),
        .flush      (id_flush),
        .hold       (id_stall),
        .next_pc    (id_pc_d),
        .next_instr (id_instr_d),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr)
    );

    assign if_id_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];

endmodule
